// File: rtl/game_pkg.sv
// Game-level constants shared by the score judge and the arrow droppers:
// the phase encoding and the start/restart keycodes.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DONE    = 2'd2
  } game_state_t;

  localparam logic [7:0] KEY_START   = 8'h2C;  // space
  localparam logic [7:0] KEY_RESTART = 8'h01;

  // Ceiling for the 10-bit hit and combo counters.
  localparam logic [9:0] CNT_MAX = 10'd1023;

  // True when either USB keycode slot carries the given key.
  function automatic logic key_seen(input logic [7:0] key_a,
                                    input logic [7:0] key_b,
                                    input logic [7:0] key);
    return (key_a == key) || (key_b == key);
  endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
  parameter int N = 16,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_count
);

  // NOTE: the accumulator starts from a default on every evaluation, so the
  // loop builds pure logic and no latch is inferred.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/score_judge.sv
// Game scorekeeper: edge-detects dropper hits, keeps score/combo/hit totals
// and sequences the Idle -> Playing -> Done phases of one song.
module score_judge
  import game_pkg::*;
#(
  parameter int N_DROPS     = 16,
  parameter int SONG_FRAMES = 2400,
  parameter int COMBO_GAP   = 120,
  parameter int BASE_PTS    = 10,
  parameter int BONUS_CAP   = 20,
  parameter int SCORE_MAX   = 9999
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [7:0]         keycode_second,
  input  logic [N_DROPS-1:0] score_in,
  output logic [1:0]         game_state,
  output logic [13:0]        score,
  output logic [9:0]         hit_count,
  output logic [9:0]         combo,
  output logic [9:0]         max_combo,
  output logic               new_hit,
  output logic               game_over
);

  localparam int PW = $clog2(N_DROPS + 1);
  localparam int GW = $clog2(COMBO_GAP + 1);

  localparam logic [11:0]   LAST_FRAME = 12'(SONG_FRAMES - 1);
  localparam logic [GW-1:0] GAP_LIMIT  = GW'(COMBO_GAP);
  localparam logic [9:0]    BONUS_LIM  = 10'(BONUS_CAP);
  localparam logic [15:0]   SCORE_LIM  = 16'(SCORE_MAX);

  game_state_t        r_state, w_state_nxt;
  logic [N_DROPS-1:0] r_score_prev;
  logic [11:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic [GW-1:0]      r_gap_cnt, w_gap_cnt_nxt;
  logic [13:0]        r_score, w_score_nxt;
  logic [9:0]         r_hit_count, w_hit_count_nxt;
  logic [9:0]         r_combo, w_combo_nxt;
  logic [9:0]         r_max_combo, w_max_combo_nxt;
  logic               r_new_hit, w_new_hit_nxt;

  logic [N_DROPS-1:0] w_hit_vec;
  logic [PW-1:0]      w_p;
  logic [9:0]         w_bonus;
  logic [15:0]        w_score_sum;
  logic [10:0]        w_hit_sum;
  logic [10:0]        w_combo_sum;
  logic [GW-1:0]      w_gap_inc;

  // A flag counts only on its 0->1 transition; a held flag is one hit.
  assign w_hit_vec = score_in & ~r_score_prev;

  popcount_n #(
    .N (N_DROPS),
    .W (PW)
  ) u_popcount (
    .i_vec   (w_hit_vec),
    .o_count (w_p)
  );

  // Every hit in a frame earns the bonus from the combo before that frame.
  assign w_bonus     = (r_combo > BONUS_LIM) ? BONUS_LIM : r_combo;
  assign w_score_sum = 16'(r_score)
                     + 16'(w_p) * (16'(BASE_PTS) + 16'(w_bonus));
  assign w_hit_sum   = {1'b0, r_hit_count} + 11'(w_p);
  assign w_combo_sum = {1'b0, r_combo} + 11'(w_p);
  assign w_gap_inc   = (r_gap_cnt >= GAP_LIMIT) ? GAP_LIMIT : r_gap_cnt + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_score_nxt     = r_score;
    w_hit_count_nxt = r_hit_count;
    w_combo_nxt     = r_combo;
    w_max_combo_nxt = r_max_combo;
    w_new_hit_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (key_seen(keycode, keycode_second, KEY_START)) begin
          w_state_nxt     = PLAYING;
          w_frame_cnt_nxt = '0;
          w_gap_cnt_nxt   = '0;
          w_score_nxt     = '0;
          w_hit_count_nxt = '0;
          w_combo_nxt     = '0;
          w_max_combo_nxt = '0;
        end
      end

      PLAYING: begin
        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
        if (w_p != '0) begin
          w_score_nxt     = (w_score_sum > SCORE_LIM) ? 14'(SCORE_LIM)
                                                      : 14'(w_score_sum);
          w_hit_count_nxt = w_hit_sum[10] ? CNT_MAX : w_hit_sum[9:0];
          w_combo_nxt     = w_combo_sum[10] ? CNT_MAX : w_combo_sum[9:0];
          w_gap_cnt_nxt   = '0;
          w_new_hit_nxt   = 1'b1;
        end else begin
          w_gap_cnt_nxt = w_gap_inc;
          if (w_gap_inc == GAP_LIMIT) begin
            w_combo_nxt = '0;
          end
        end
        if (w_combo_nxt > r_max_combo) begin
          w_max_combo_nxt = w_combo_nxt;
        end
        // The final frame's hits are already folded in above.
        if (r_frame_cnt == LAST_FRAME) begin
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        if (key_seen(keycode, keycode_second, KEY_RESTART)) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_score_prev <= '0;
      r_frame_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_score      <= '0;
      r_hit_count  <= '0;
      r_combo      <= '0;
      r_max_combo  <= '0;
      r_new_hit    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_score_prev <= score_in;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_score      <= w_score_nxt;
      r_hit_count  <= w_hit_count_nxt;
      r_combo      <= w_combo_nxt;
      r_max_combo  <= w_max_combo_nxt;
      r_new_hit    <= w_new_hit_nxt;
    end
  end

  assign game_state = r_state;
  assign score      = r_score;
  assign hit_count  = r_hit_count;
  assign combo      = r_combo;
  assign max_combo  = r_max_combo;
  assign new_hit    = r_new_hit;
  assign game_over  = (r_state == DONE);

endmodule

// File: tb/tb_score_judge.sv
// Directed bench for score_judge: phase sequencing, edge-detected scoring,
// combo bonus and timeout, saturation and song end.
module tb_score_judge;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic [7:0]  keycode_second;
  logic [15:0] score_in;
  logic [1:0]  game_state;
  logic [13:0] score;
  logic [9:0]  hit_count;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic        new_hit;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;
  int n_play   = 0;

  score_judge dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .keycode_second (keycode_second),
    .score_in       (score_in),
    .game_state     (game_state),
    .score          (score),
    .hit_count      (hit_count),
    .combo          (combo),
    .max_combo      (max_combo),
    .new_hit        (new_hit),
    .game_over      (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic play_step();
    step();
    n_play++;
  endtask

  task automatic check_totals(input string tag, input int exp_score,
                              input int exp_hits, input int exp_combo,
                              input int exp_max);
    check({tag, ".score"},     int'(score),     exp_score);
    check({tag, ".hits"},      int'(hit_count), exp_hits);
    check({tag, ".combo"},     int'(combo),     exp_combo);
    check({tag, ".max_combo"}, int'(max_combo), exp_max);
  endtask

  initial begin
    Reset          = 1'b1;
    keycode        = 8'h00;
    keycode_second = 8'h00;
    score_in       = 16'h0000;
    step();
    step();
    Reset = 1'b0;
    check("reset.state", int'(game_state), 0);
    check_totals("reset", 0, 0, 0, 0);
    check("reset.new_hit", int'(new_hit), 0);
    check("reset.game_over", int'(game_over), 0);

    // A rising flag in Idle scores nothing.
    score_in = 16'h0001;
    step();
    check("idle_hit.score", int'(score), 0);
    check("idle_hit.hits", int'(hit_count), 0);
    check("idle_hit.new_hit", int'(new_hit), 0);
    score_in = 16'h0000;
    step();

    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    check("start.state", int'(game_state), 1);

    score_in = 16'h0008;
    step();
    check_totals("first_hit", 10, 1, 1, 1);
    check("first_hit.new_hit", int'(new_hit), 1);
    step();
    check("hold.score", int'(score), 10);
    check("hold.new_hit", int'(new_hit), 0);

    // Reset in the middle of a game.
    Reset    = 1'b1;
    score_in = 16'h0000;
    step();
    Reset = 1'b0;
    check("mid_reset.state", int'(game_state), 0);
    check_totals("mid_reset", 0, 0, 0, 0);

    // Second game: run it through to the end of the song.
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    n_play  = 0;
    check("start2.state", int'(game_state), 1);

    // Five single hits on consecutive frames: 10+11+12+13+14.
    for (int k = 0; k < 5; k++) begin
      score_in = 16'(1 << k);
      play_step();
    end
    check_totals("five_hits", 60, 5, 5, 5);

    // Bits 1,2,5 rise together at combo 5: 3*(10+5).
    score_in = 16'h0026;
    play_step();
    check_totals("triple", 105, 8, 8, 8);

    // Combo survives 119 quiet frames and clears on the 120th.
    score_in = 16'h0000;
    for (int k = 0; k < 119; k++) play_step();
    check("gap119.combo", int'(combo), 8);
    play_step();
    check("gap120.combo", int'(combo), 0);
    check("gap120.max_combo", int'(max_combo), 8);

    score_in = 16'h0001;
    play_step();
    check_totals("after_gap", 115, 9, 1, 8);

    // Sixteen-hit frames: bonus 1, then 17, then capped at 20.
    for (int k = 0; k < 21; k++) begin
      score_in = 16'h0000;
      play_step();
      score_in = 16'hFFFF;
      play_step();
    end
    check_totals("burst21", 9843, 345, 337, 337);

    score_in = 16'h0000;
    play_step();
    score_in = 16'hFFFF;
    play_step();
    check_totals("saturate", 9999, 361, 353, 353);

    score_in = 16'h0000;
    play_step();
    score_in = 16'hFFFF;
    play_step();
    check_totals("saturate_hold", 9999, 377, 369, 369);

    score_in = 16'h0000;
    while (n_play < 2399) play_step();
    check("pre_end.state", int'(game_state), 1);
    check("pre_end.combo", int'(combo), 0);

    // Hit on the last song frame still counts.
    score_in = 16'h0001;
    play_step();
    check("end.state", int'(game_state), 2);
    check("end.game_over", int'(game_over), 1);
    check_totals("end", 9999, 378, 1, 369);
    check("end.new_hit", int'(new_hit), 1);

    // Done: no accumulation, start key ignored.
    score_in = 16'h0003;
    keycode  = 8'h2C;
    step();
    keycode = 8'h00;
    check("done.state", int'(game_state), 2);
    check("done.hits", int'(hit_count), 378);
    check("done.new_hit", int'(new_hit), 0);

    keycode_second = 8'h01;
    step();
    keycode_second = 8'h00;
    check("restart.state", int'(game_state), 0);
    check("restart.game_over", int'(game_over), 0);
    check_totals("restart", 9999, 378, 1, 369);

    // Restart key in Idle is ignored.
    keycode = 8'h01;
    step();
    keycode = 8'h00;
    check("idle_restart.state", int'(game_state), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
